// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-style control FSM with combinational control outputs and a retired-instruction counter
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic        illegal_op,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
                         MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9;
  logic [3:0]  state_q, state_d;
  logic [31:0] count_q;
  logic        retire;
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    illegal_op    = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = 2'b00;
    state_d       = FETCH;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J});
        state_d    = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                     (opcode == OP_RTYPE) ? EXECUTE :
                     (opcode == OP_BEQ) ? BRANCH :
                     (opcode == OP_J) ? JUMP : FETCH;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: state_d = FETCH;
    endcase
  end
  assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                  (state_q == JUMP) || (state_q == MEMWR && mem_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + 32'(retire);
    end
  end
  assign state       = state_q;
  assign instr_count = count_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, pc_src, alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;
  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .illegal_op(illegal_op), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_op(alu_op), .state(state), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BQ = 6'b000100, JP = 6'b000010, BAD = 6'b111111;
  // field order: pw pwc iord mr mw irw m2r rd rw asa ill asb pcs aop
  localparam logic [16:0] C_FR  = 17'b1_0_0_1_0_1_0_0_0_0_0_01_00_00;
  localparam logic [16:0] C_FW  = 17'b0_0_0_1_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] C_DEC = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] C_ILL = 17'b0_0_0_0_0_0_0_0_0_0_1_11_00_00;
  localparam logic [16:0] C_MA  = 17'b0_0_0_0_0_0_0_0_0_1_0_10_00_00;
  localparam logic [16:0] C_MR  = 17'b0_0_1_1_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_MWB = 17'b0_0_0_0_0_0_1_0_1_0_0_00_00_00;
  localparam logic [16:0] C_MW  = 17'b0_0_1_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_EX  = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_10;
  localparam logic [16:0] C_AWB = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [16:0] C_BR  = 17'b0_1_0_0_0_0_0_0_0_1_0_00_01_01;
  localparam logic [16:0] C_JP  = 17'b1_0_0_0_0_0_0_0_0_0_0_00_10_00;
  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } exp_t;
  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0, vec = 0;
  logic [16:0] ctl_act;
  assign ctl_act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, illegal_op, alu_src_b, pc_src, alu_op};
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp += 3;
      if (state !== e.st) begin
        n_bad++;
        $display("FAIL vec%0d state: got %0d want %0d", e.idx, state, e.st);
      end
      if (ctl_act !== e.ctl) begin
        n_bad++;
        $display("FAIL vec%0d ctrl: got %b want %b", e.idx, ctl_act, e.ctl);
      end
      if (instr_count !== e.cnt) begin
        n_bad++;
        $display("FAIL vec%0d instr_count: got %0d want %0d", e.idx, instr_count, e.cnt);
      end
    end
  end
  task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [16:0] ctl, input logic [31:0] cnt);
    rst_n = r;
    opcode = op;
    mem_ready = mr;
    sb.push_back('{vec, st, ctl, cnt});
    vec++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    opcode = RT;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, RT, 0, 0, C_FW, 0);
    cyc(1, LW, 1, 0, C_FR, 0);
    cyc(1, LW, 1, 1, C_DEC, 0);
    cyc(1, LW, 1, 2, C_MA, 0);
    cyc(1, LW, 1, 3, C_MR, 0);
    cyc(1, LW, 1, 4, C_MWB, 0);
    cyc(1, SW, 0, 0, C_FW, 1);
    cyc(1, SW, 1, 0, C_FR, 1);
    cyc(1, SW, 0, 1, C_DEC, 1);
    cyc(1, SW, 0, 2, C_MA, 1);
    cyc(1, SW, 0, 5, C_MW, 1);
    cyc(1, SW, 0, 5, C_MW, 1);
    cyc(1, SW, 0, 5, C_MW, 1);
    cyc(1, SW, 1, 5, C_MW, 1);
    cyc(1, RT, 1, 0, C_FR, 2);
    cyc(1, RT, 0, 1, C_DEC, 2);
    cyc(1, RT, 0, 6, C_EX, 2);
    cyc(1, RT, 1, 7, C_AWB, 2);
    cyc(1, BQ, 1, 0, C_FR, 3);
    cyc(1, BQ, 0, 1, C_DEC, 3);
    cyc(1, BQ, 1, 8, C_BR, 3);
    cyc(1, JP, 1, 0, C_FR, 4);
    cyc(1, JP, 1, 1, C_DEC, 4);
    cyc(1, JP, 0, 9, C_JP, 4);
    cyc(1, BAD, 1, 0, C_FR, 5);
    cyc(1, BAD, 1, 1, C_ILL, 5);
    cyc(1, LW, 1, 0, C_FR, 5);
    cyc(1, LW, 1, 1, C_DEC, 5);
    cyc(1, LW, 1, 2, C_MA, 5);
    cyc(1, LW, 0, 3, C_MR, 5);
    cyc(1, LW, 0, 3, C_MR, 5);
    cyc(0, LW, 1, 3, C_MR, 5);
    cyc(1, LW, 0, 0, C_FW, 0);
    cyc(1, LW, 1, 0, C_FR, 0);
    cyc(1, LW, 1, 1, C_DEC, 0);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: OP_RTYPE, 6'b000000, R-type; OP_LW, 6'b100011, load word; OP_SW, 6'b101011, store word; OP_BEQ, 6'b000100, branch-equal; OP_J, 6'b000010, jump.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows; single clock, reset synchronous active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 opcode  in  6  instruction[31:26] from the instruction register; stable after FETCH completes.
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 Outputs, 1 bit each: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op.
REQ-008 Outputs, 2 bits each: alu_src_b (00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2), pc_src (00 ALU result, 01 ALUOut, 10 jump target), alu_op (00 add/mem, 01 sub/beq, 10 decode funct; consumed by ALUCTRL).
REQ-009 Outputs, wider: state out 4 (current state code); instr_count out 32 (retired-instruction count).

Function
REQ-010 State codes SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9; a single 4-bit state register.
REQ-011 Control outputs SHALL be combinational from state (plus mem_ready and opcode where stated); any output not listed for a state SHALL be 0.
REQ-012 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_write=mem_ready; next DECODE if mem_ready, else stay in FETCH.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, J->JUMP.
REQ-014 DECODE with any other opcode: illegal_op=1 that cycle only; next FETCH; instr_count unchanged.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD if opcode=LW, else MEMWR.
REQ-016 MEMRD: mem_read=1, iord=1; next MEMWB if mem_ready, else stay.
REQ-017 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-018 MEMWR: mem_write=1, iord=1; next FETCH if mem_ready, else stay (mem_write held high while waiting).
REQ-019 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB.
REQ-020 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; next FETCH.
REQ-022 JUMP: pc_write=1, pc_src=10; next FETCH.
REQ-023 Unused codes 10-15: all strobes 0, alu_op=00; next FETCH; no count change.
REQ-024 instr_count SHALL increment by 1 (mod 2^32, wraps to 0) on each clock edge leaving MEMWB, ALUWB, BRANCH, JUMP, or MEMWR with mem_ready=1.
REQ-025 Latency with mem_ready held 1: lw 5 cycles, sw/R-type 4, beq/j 3, illegal 2.
REQ-026 mem_ready SHALL be ignored in all states except FETCH, MEMRD and MEMWR.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force state=FETCH and instr_count=0, overriding any transition or increment that edge, from any state including mid-wait.
REQ-028 Out of reset, outputs SHALL be the FETCH values of REQ-012 (mem_read=1, alu_src_b=01, others 0 with mem_ready=0).

Verification
REQ-029 Reset, then opcode=100011, mem_ready=1 -> state 0,1,2,3,4,0; reg_write=mem_to_reg=1 only in state 4; instr_count=1.
REQ-030 opcode=101011, mem_ready low 3 cycles in MEMWR -> state held at 5 with mem_write=1 for 4 cycles; then FETCH; instr_count +1.
REQ-031 opcode=000000 -> states 0,1,6,7,0; alu_op=10 in state 6; reg_dst=reg_write=1 in state 7.
REQ-032 opcode=000100 then 000010 -> beq: state 8, alu_op=01, pc_write_cond=1, pc_src=01; j: state 9, pc_write=1, pc_src=10; instr_count +2.
REQ-033 opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE; back to FETCH; instr_count unchanged.
REQ-034 rst_n=0 while waiting in MEMRD after instr_count=5 -> next edge state=0, instr_count=0, no reg_write pulse.
